// File: rtl/fir_dma_pkg.sv
// Shared types and constants for the FIR DMA sequencer.
// Holds the FSM state encoding and the BRAM constants used by the design and its bench.
package fir_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    PUSH,
    POP,
    WR
  } state_e;

  localparam logic [31:0] BRAM_BASE = 32'h3800_0000;
  localparam logic [3:0]  WSTRB_ALL = 4'hF;

endpackage

// File: rtl/fir_dma_ctrl.sv
// Block sequencer: streams samples from user BRAM into the FIR and writes each result back.
// Shares the BRAM port with Wishbone via dma_req/dma_gnt; strictly one sample in flight.
module fir_dma_ctrl
  import fir_dma_pkg::*;
#(
  parameter int LEN_W   = 11,
  parameter int TIMEOUT = 1024,
  parameter int TMR_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] count,
  output logic             dma_req,
  input  logic             dma_gnt,
  output logic             bram_en,
  output logic [3:0]       bram_we,
  output logic [31:0]      bram_addr,
  output logic [31:0]      bram_di,
  input  logic [31:0]      bram_do,
  output logic             ss_tvalid,
  input  logic             ss_tready,
  output logic [31:0]      ss_tdata,
  output logic             ss_tlast,
  input  logic             sm_tvalid,
  output logic             sm_tready,
  input  logic [31:0]      sm_tdata
);

  state_e             state_q, state_d;
  logic [31:0]        srcAddr_q, srcAddr_d;
  logic [31:0]        dstAddr_q, dstAddr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [31:0]        sample_q, sample_d;
  logic [31:0]        result_q, result_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [LEN_W-1:0]   count_q, count_d;

  logic               isLast;
  logic               timerExpired;
  logic [31:0]        rdAddr;
  logic [31:0]        wrAddr;

  assign isLast       = (idx_q == len_q - LEN_W'(1));
  assign timerExpired = (timer_q == TMR_W'(TIMEOUT - 1));
  assign rdAddr       = srcAddr_q + (32'(idx_q) << 2);
  assign wrAddr       = dstAddr_q + (32'(idx_q) << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      srcAddr_q <= '0;
      dstAddr_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      sample_q  <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      srcAddr_q <= srcAddr_d;
      dstAddr_q <= dstAddr_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      sample_q  <= sample_d;
      result_q  <= result_d;
      done_q    <= done_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    srcAddr_d = srcAddr_q;
    dstAddr_d = dstAddr_q;
    len_d     = len_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    sample_d  = sample_q;
    result_d  = result_q;
    done_d    = done_q;
    err_d     = err_q;
    count_d   = count_q;
    dma_req   = 1'b0;
    bram_en   = 1'b0;
    bram_we   = 4'h0;
    bram_addr = 32'h0;
    bram_di   = 32'h0;
    ss_tvalid = 1'b0;
    ss_tdata  = 32'h0;
    ss_tlast  = 1'b0;
    sm_tready = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          done_d  = (len == '0);
          err_d   = 1'b0;
          count_d = '0;
          if (len != '0) begin
            srcAddr_d = src_addr;
            dstAddr_d = dst_addr;
            len_d     = len;
            idx_d     = '0;
            state_d   = RD_REQ;
          end
        end
      end

      RD_REQ: begin
        dma_req = 1'b1;
        if (dma_gnt) begin
          bram_en   = 1'b1;
          bram_addr = rdAddr;
        end
        if (abort)        state_d = IDLE;
        else if (dma_gnt) state_d = RD_WAIT;
      end

      RD_WAIT: begin
        sample_d = bram_do;
        state_d  = abort ? IDLE : PUSH;
      end

      // abort is only honoured once the FIR has taken the sample, so valid never drops early
      PUSH: begin
        ss_tvalid = 1'b1;
        ss_tdata  = sample_q;
        ss_tlast  = isLast;
        if (ss_tready) begin
          timer_d = '0;
          state_d = abort ? IDLE : POP;
        end
      end

      POP: begin
        sm_tready = 1'b1;
        if (sm_tvalid) begin
          result_d = sm_tdata;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
        if (abort) begin
          state_d = IDLE;
        end else if (sm_tvalid) begin
          state_d = WR;
        end else if (timerExpired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      WR: begin
        dma_req = 1'b1;
        if (dma_gnt) begin
          bram_en   = 1'b1;
          bram_we   = WSTRB_ALL;
          bram_addr = wrAddr;
          bram_di   = result_q;
          count_d   = count_q + LEN_W'(1);
          if (abort) begin
            state_d = IDLE;
          end else if (isLast) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = RD_REQ;
          end
        end else if (abort) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign err   = err_q;
  assign count = count_q;

endmodule

// File: tb/tb_fir_dma_ctrl.sv
// Directed bench for fir_dma_ctrl: BRAM and a doubling FIR are modelled here, checks use immediate assertions.
module tb_fir_dma_ctrl;
  import fir_dma_pkg::*;

  localparam int LEN_W   = 11;
  localparam int TIMEOUT = 16;
  localparam int TMR_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             err;
  logic [LEN_W-1:0] count;
  logic             dma_req;
  logic             dma_gnt = 1'b1;
  logic             bram_en;
  logic [3:0]       bram_we;
  logic [31:0]      bram_addr;
  logic [31:0]      bram_di;
  logic [31:0]      bram_do = 32'h0;
  logic             ss_tvalid;
  logic             ss_tready;
  logic [31:0]      ss_tdata;
  logic             ss_tlast;
  logic             sm_tvalid;
  logic             sm_tready;
  logic [31:0]      sm_tdata;

  logic             firEnable;
  logic             gntRandom;
  logic             firPending = 1'b0;
  logic [31:0]      firData = 32'h0;
  logic [31:0]      mem [256];
  logic [7:0]       tlastLog = 8'h0;
  int               cycleCnt = 0;
  int               hsCount = 0;
  int               hsCycle = 0;
  int               reqSeen = 0;
  int               enViolations = 0;
  int               addrErr = 0;
  int               assertCount = 0;
  int               failCount = 0;
  int               snap;
  logic [31:0]      exp1 [4] = '{32'd2, 32'd4, 32'd6, 32'd8};

  fir_dma_ctrl #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err), .count(count),
    .dma_req(dma_req), .dma_gnt(dma_gnt),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_di(bram_di), .bram_do(bram_do),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata)
  );

  always #5 clk = ~clk;

  assign sm_tvalid = firPending;
  assign sm_tdata  = firData;

  always @(negedge clk) dma_gnt = gntRandom ? 1'($urandom_range(0, 1)) : 1'b1;

  // BRAM with one-cycle read latency, a 1-in/1-out FIR computing in*2, and activity monitors
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = (i < 4) ? 32'(i + 1) : (32'hDEAD_0000 | 32'(i));
    forever begin
      @(posedge clk);
      cycleCnt++;
      if (bram_en && !dma_gnt) enViolations++;
      if (dma_req || ss_tvalid || sm_tready) reqSeen++;
      if (bram_en) begin
        if ((bram_addr - BRAM_BASE) >= 32'd1024) addrErr++;
        if (bram_we == WSTRB_ALL) mem[bram_addr[9:2]] = bram_di;
        bram_do <= mem[bram_addr[9:2]];
      end
      if (sm_tvalid && sm_tready) firPending <= 1'b0;
      if (ss_tvalid && ss_tready) begin
        hsCount++;
        hsCycle  = cycleCnt;
        tlastLog = {tlastLog[6:0], ss_tlast};
        if (firEnable) begin
          firPending <= 1'b1;
          firData    <= ss_tdata * 32'd2;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] srcA, input logic [31:0] dstA, input int n);
    src_addr = srcA;
    dst_addr = dstA;
    len      = LEN_W'(n);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int bound);
    for (int i = 0; i < bound && done !== 1'b1; i++) @(negedge clk);
    checkOutput({tag, " done"}, 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; len = '0;
    src_addr = 32'h0; dst_addr = 32'h0;
    ss_tready = 1'b1; firEnable = 1'b1; gntRandom = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset flags", 32'({busy, done, err, dma_req, bram_en, ss_tvalid, sm_tready}), 32'd0);
    checkOutput("reset count", 32'(count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: four samples, grant always present
    applyStimulus(BRAM_BASE, BRAM_BASE + 32'h100, 4);
    waitDone("t1", 200);
    checkOutput("t1 count", 32'(count), 32'd4);
    checkOutput("t1 busy", 32'(busy), 32'd0);
    checkOutput("t1 err", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t1 mem%0d", i), mem[64 + i], exp1[i]);
    checkOutput("t1 tlast", 32'(tlastLog), 32'h01);

    // 2: same block with a 50% random grant
    gntRandom = 1'b1;
    applyStimulus(BRAM_BASE, BRAM_BASE + 32'h200, 4);
    checkOutput("t2 done cleared", 32'(done), 32'd0);
    checkOutput("t2 busy", 32'(busy), 32'd1);
    waitDone("t2", 600);
    gntRandom = 1'b0;
    checkOutput("t2 count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t2 mem%0d", i), mem[128 + i], exp1[i]);
    checkOutput("t2 en without gnt", 32'(enViolations), 32'd0);
    @(negedge clk);

    // 3: back-pressure in PUSH holds the stream stable
    ss_tready = 1'b0;
    applyStimulus(BRAM_BASE, BRAM_BASE + 32'h300, 1);
    for (int i = 0; i < 20 && ss_tvalid !== 1'b1; i++) @(negedge clk);
    snap = hsCount;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("t3 tvalid c%0d", k), 32'(ss_tvalid), 32'd1);
      checkOutput($sformatf("t3 tdata c%0d", k), ss_tdata, 32'd1);
      @(negedge clk);
    end
    ss_tready = 1'b1;
    waitDone("t3", 50);
    checkOutput("t3 transfers", 32'(hsCount - snap), 32'd1);
    checkOutput("t3 tlast", 32'(tlastLog[0]), 32'd1);
    checkOutput("t3 mem", mem[192], 32'd2);

    // 4: FIR never answers, timeout fires 16 cycles after the handshake
    firEnable = 1'b0;
    applyStimulus(BRAM_BASE, BRAM_BASE + 32'h340, 1);
    for (int i = 0; i < 100 && err !== 1'b1; i++) @(negedge clk);
    checkOutput("t4 err", 32'(err), 32'd1);
    checkOutput("t4 latency", 32'(cycleCnt - hsCycle), 32'd16);
    checkOutput("t4 busy", 32'(busy), 32'd0);
    checkOutput("t4 done", 32'(done), 32'd0);
    checkOutput("t4 no write", mem[208], 32'hDEAD_00D0);
    firEnable = 1'b1;
    @(negedge clk);

    // 5: zero-length block completes immediately with no traffic
    snap = reqSeen;
    applyStimulus(BRAM_BASE, BRAM_BASE + 32'h340, 0);
    checkOutput("t5 done", 32'(done), 32'd1);
    checkOutput("t5 busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("t5 no activity", 32'(reqSeen - snap), 32'd0);

    // 6: abort while waiting for the second FIR result
    applyStimulus(BRAM_BASE, BRAM_BASE + 32'h380, 4);
    for (int i = 0; i < 100 && count !== LEN_W'(1); i++) @(negedge clk);
    firEnable = 1'b0;
    for (int i = 0; i < 100 && sm_tready !== 1'b1; i++) @(negedge clk);
    checkOutput("t6 in POP", 32'(sm_tready), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("t6 busy", 32'(busy), 32'd0);
    checkOutput("t6 count", 32'(count), 32'd1);
    checkOutput("t6 done/err", 32'({done, err}), 32'd0);
    checkOutput("t6 mem0", mem[224], 32'd2);
    checkOutput("t6 mem1", mem[225], 32'hDEAD_00E1);
    firEnable = 1'b1;
    @(negedge clk);
    applyStimulus(BRAM_BASE, BRAM_BASE + 32'h3C0, 2);
    waitDone("t6 fresh", 100);
    checkOutput("t6 fresh count", 32'(count), 32'd2);
    checkOutput("t6 fresh mem0", mem[240], 32'd2);
    checkOutput("t6 fresh mem1", mem[241], 32'd4);

    // 6b: synchronous reset in the middle of a write
    applyStimulus(BRAM_BASE, BRAM_BASE + 32'h100, 4);
    for (int i = 0; i < 50 && bram_we !== WSTRB_ALL; i++) @(negedge clk);
    checkOutput("t6b in WR", 32'(bram_we), 32'hF);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6b ctrl zero",
                32'({busy, done, err, count, dma_req, bram_en, bram_we, ss_tvalid, ss_tlast, sm_tready}),
                32'd0);
    checkOutput("t6b data zero", bram_addr | bram_di | ss_tdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("address range", 32'(addrErr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
